version_info_streamer: RTL and testbench



---
 rtl/version_info_streamer.sv | 151 +++++++++++++++
 tb/tb_version_info_streamer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/version_info_streamer.sv
// Build-identification streamer: emits a framed, checksummed record of version,
// BCD build timestamp and optional user bytes over an 8-bit valid/ready stream.
module version_info_streamer #(
    parameter logic [7:0]  C_MAJOR       = 8'd0,
    parameter logic [7:0]  C_MINOR       = 8'd0,
    parameter logic [7:0]  C_PATCH       = 8'd0,
    parameter logic [7:0]  C_BUILD       = 8'd0,
    parameter logic [15:0] C_YEAR        = 16'h2025,
    parameter logic [7:0]  C_MONTH       = 8'h01,
    parameter logic [7:0]  C_DAY         = 8'h01,
    parameter logic [7:0]  C_HOUR        = 8'h00,
    parameter logic [7:0]  C_MINUTE      = 8'h00,
    parameter logic [7:0]  C_SECOND      = 8'h00,
    parameter logic [7:0]  C_MAGIC       = 8'hA5,
    parameter int unsigned N_USER        = 0,
    parameter int unsigned C_AUTO_PERIOD = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req,
    input  logic [((N_USER > 0) ? N_USER : 1)*8-1:0] user_data,
    output logic [7:0]                           m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_last,
    output logic                                 busy,
    output logic [15:0]                          frame_cnt
);

    localparam int unsigned UW        = ((N_USER > 0) ? N_USER : 1) * 8;
    localparam logic [4:0]  LP_LAST   = 5'(13 + N_USER);
    localparam logic [7:0]  LP_LEN    = 8'(11 + N_USER);
    localparam logic [31:0] LP_PERIOD = 32'(C_AUTO_PERIOD);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [4:0]    r_idx;
    logic [7:0]    r_sum;
    logic [UW-1:0] r_user;
    logic          r_pending;
    logic [31:0]   r_timer;
    logic [15:0]   r_frame_cnt;

    logic       w_auto_tick;
    logic       w_req_any;
    logic       w_accept;
    logic       w_is_last;
    logic       w_load;
    logic [7:0] w_byte;

    assign w_auto_tick = (LP_PERIOD != 32'd0) && (r_timer == LP_PERIOD - 32'd1);
    assign w_req_any   = req | w_auto_tick;
    assign w_is_last   = (r_idx == LP_LAST);
    assign w_accept    = (r_state == S_SEND) && m_ready;

    // User bytes leave from the top of a shift register, so MSB byte goes first.
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            5'd0:    w_byte = C_MAGIC;
            5'd1:    w_byte = LP_LEN;
            5'd2:    w_byte = C_MAJOR;
            5'd3:    w_byte = C_MINOR;
            5'd4:    w_byte = C_PATCH;
            5'd5:    w_byte = C_BUILD;
            5'd6:    w_byte = C_YEAR[15:8];
            5'd7:    w_byte = C_YEAR[7:0];
            5'd8:    w_byte = C_MONTH;
            5'd9:    w_byte = C_DAY;
            5'd10:   w_byte = C_HOUR;
            5'd11:   w_byte = C_MINUTE;
            5'd12:   w_byte = C_SECOND;
            default: w_byte = w_is_last ? (8'h00 - r_sum) : r_user[UW-1 -: 8];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        busy         = 1'b0;
        m_data       = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_req_any || r_pending) begin
                    w_state_next = S_SEND;
                    w_load       = 1'b1;
                end
            end
            S_SEND: begin
                m_valid = 1'b1;
                busy    = 1'b1;
                m_data  = w_byte;
                m_last  = w_is_last;
                // A request arriving with the CHK accept chains straight into the next frame.
                if (w_accept && w_is_last) begin
                    if (r_pending || w_req_any) w_load = 1'b1;
                    else                        w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_sum     <= '0;
            r_user    <= '0;
            r_pending <= 1'b0;
        end else if (w_load) begin
            r_idx     <= '0;
            r_sum     <= '0;
            r_user    <= user_data;
            r_pending <= 1'b0;
        end else if (r_state == S_SEND) begin
            if (w_req_any) r_pending <= 1'b1;
            if (w_accept) begin
                r_idx <= r_idx + 5'd1;
                if (r_idx != 5'd0) r_sum <= r_sum + w_byte;
                if (r_idx >= 5'd13) r_user <= r_user << 8;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_frame_cnt <= '0;
        else if (w_accept && w_is_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_timer <= '0;
        else if (LP_PERIOD == 32'd0) r_timer <= '0;
        else if (w_auto_tick)      r_timer <= '0;
        else                       r_timer <= r_timer + 32'd1;
    end

    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_version_info_streamer.sv
// Directed self-checking bench for version_info_streamer: three instances cover
// the base record, user bytes, and the periodic auto-request timer.
module tb_version_info_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: N_USER=0, no auto period
    logic        rst_n_a = 1'b0, req_a = 1'b0, rdy_a = 1'b1;
    logic [7:0]  ud_a = 8'h00;
    logic [7:0]  data_a;
    logic        valid_a, last_a, busy_a;
    logic [15:0] cnt_a;

    version_info_streamer #(
        .C_BUILD(8'd52), .C_YEAR(16'h2025), .C_MONTH(8'h11), .C_DAY(8'h05),
        .C_HOUR(8'h12), .C_MINUTE(8'h22), .C_SECOND(8'h09), .N_USER(0), .C_AUTO_PERIOD(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_a), .req(req_a), .user_data(ud_a),
        .m_data(data_a), .m_valid(valid_a), .m_ready(rdy_a), .m_last(last_a),
        .busy(busy_a), .frame_cnt(cnt_a)
    );

    // Instance B: two user bytes
    logic        rst_n_b = 1'b0, req_b = 1'b0, rdy_b = 1'b1;
    logic [15:0] ud_b = 16'hBEEF;
    logic [7:0]  data_b;
    logic        valid_b, last_b, busy_b;
    logic [15:0] cnt_b;

    version_info_streamer #(
        .C_BUILD(8'd52), .C_YEAR(16'h2025), .C_MONTH(8'h11), .C_DAY(8'h05),
        .C_HOUR(8'h12), .C_MINUTE(8'h22), .C_SECOND(8'h09), .N_USER(2), .C_AUTO_PERIOD(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .req(req_b), .user_data(ud_b),
        .m_data(data_b), .m_valid(valid_b), .m_ready(rdy_b), .m_last(last_b),
        .busy(busy_b), .frame_cnt(cnt_b)
    );

    // Instance C: auto period 100
    logic        rst_n_c = 1'b0, req_c = 1'b0, rdy_c = 1'b1;
    logic [7:0]  ud_c = 8'h00;
    logic [7:0]  data_c;
    logic        valid_c, last_c, busy_c;
    logic [15:0] cnt_c;

    version_info_streamer #(
        .C_BUILD(8'd52), .C_YEAR(16'h2025), .C_MONTH(8'h11), .C_DAY(8'h05),
        .C_HOUR(8'h12), .C_MINUTE(8'h22), .C_SECOND(8'h09), .N_USER(0), .C_AUTO_PERIOD(100)
    ) dut_c (
        .clk(clk), .rst_n(rst_n_c), .req(req_c), .user_data(ud_c),
        .m_data(data_c), .m_valid(valid_c), .m_ready(rdy_c), .m_last(last_c),
        .busy(busy_c), .frame_cnt(cnt_c)
    );

    logic [7:0] exp_a [0:13];
    logic [7:0] exp_b [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receive one frame from instance A; bp=1 applies random backpressure.
    task automatic recv_a(input bit bp);
        int         got = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (got < 14 && cyc < 400) begin
            rdy_a = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #0;
            check("a_valid_in_frame", {31'd0, valid_a}, 32'd1);
            if (stalled) check("a_stall_stable", {24'd0, data_a}, {24'd0, held});
            if (rdy_a) begin
                check($sformatf("a_byte%0d", got), {24'd0, data_a}, {24'd0, exp_a[got]});
                check($sformatf("a_last%0d", got), {31'd0, last_a}, {31'd0, (got == 13)});
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = data_a;
            end
            tick();
            cyc++;
        end
        rdy_a = 1'b1;
        if (got < 14) check("a_frame_timeout", got, 14);
    endtask

    initial begin
        logic [7:0]  sum;
        logic [15:0] base;
        int          first_start, second_start, k;
        logic        prev_v;

        exp_a = '{8'hA5, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h34, 8'h20, 8'h25,
                  8'h11, 8'h05, 8'h12, 8'h22, 8'h09, 8'h29};
        exp_b = '{8'hA5, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h34, 8'h20, 8'h25,
                  8'h11, 8'h05, 8'h12, 8'h22, 8'h09, 8'hBE, 8'hEF, 8'h7A};

        tick(); tick();
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_last",  {31'd0, last_a},  32'd0);
        check("rst_data",  {24'd0, data_a},  32'd0);
        check("rst_busy",  {31'd0, busy_a},  32'd0);
        check("rst_cnt",   {16'd0, cnt_a},   32'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick();
        check("idle_valid", {31'd0, valid_a}, 32'd0);

        // Basic frame, one-cycle start latency
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        check("latency_magic", {23'd0, valid_a, data_a}, {23'd0, 1'b1, 8'hA5});
        recv_a(1'b0);
        check("s1_cnt",      {16'd0, cnt_a},   32'd1);
        check("s1_idle",     {31'd0, valid_a}, 32'd0);

        // Backpressure
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        recv_a(1'b1);
        check("bp_cnt", {16'd0, cnt_a}, 32'd2);

        // Three requests in one frame queue exactly one; req on CHK accept chains
        base  = cnt_a;
        req_a = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            req_a = (i == 3 || i == 5 || i == 7);
            #0;
            check($sformatf("q1_byte%0d", i), {24'd0, data_a}, {24'd0, exp_a[i]});
            tick();
        end
        req_a = 1'b0;
        check("q_nobubble", {23'd0, valid_a, data_a}, {23'd0, 1'b1, 8'hA5});
        for (int i = 0; i < 14; i++) begin
            req_a = (i == 13);
            #0;
            check($sformatf("q2_byte%0d", i), {24'd0, data_a}, {24'd0, exp_a[i]});
            tick();
        end
        req_a = 1'b0;
        check("coinc_nobubble", {23'd0, valid_a, data_a}, {23'd0, 1'b1, 8'hA5});
        recv_a(1'b0);
        tick();
        check("q_idle_after", {31'd0, valid_a}, 32'd0);
        check("q_cnt", {16'd0, cnt_a}, {16'd0, base + 16'd3});

        // Asynchronous reset during byte 6 with a request pending
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req_a = 1'b1;
            tick();
            req_a = 1'b0;
        end
        check("pre_rst_byte6", {24'd0, data_a}, {24'd0, exp_a[5]});
        #2;
        rst_n_a = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, valid_a}, 32'd0);
        check("async_rst_cnt",   {16'd0, cnt_a},   32'd0);
        tick();
        rst_n_a = 1'b1;
        tick(); tick();
        check("pending_dropped", {31'd0, valid_a}, 32'd0);
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        recv_a(1'b0);
        check("post_rst_cnt", {16'd0, cnt_a}, 32'd1);

        // Counter wrap
        force dut_a.r_frame_cnt = 16'hFFFF;
        tick();
        release dut_a.r_frame_cnt;
        check("preload_cnt", {16'd0, cnt_a}, 32'h0000FFFF);
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        recv_a(1'b0);
        check("wrap_cnt", {16'd0, cnt_a}, 32'd0);

        // User bytes; user_data change mid-frame is ignored
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        ud_b  = 16'h1234;
        sum   = 8'h00;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b_byte%0d", i), {24'd0, data_b}, {24'd0, exp_b[i]});
            check($sformatf("b_last%0d", i), {31'd0, last_b}, {31'd0, (i == 15)});
            if (i >= 1) sum = sum + data_b;
            tick();
        end
        check("b_sum_zero", {24'd0, sum}, 32'd0);
        check("b_cnt", {16'd0, cnt_b}, 32'd1);

        // Auto period
        first_start  = -1;
        second_start = -1;
        prev_v       = 1'b0;
        rst_n_c      = 1'b1;
        for (k = 1; k <= 1050; k++) begin
            tick();
            if (valid_c && !prev_v) begin
                if (first_start < 0)       first_start  = k;
                else if (second_start < 0) second_start = k;
            end
            prev_v = valid_c;
        end
        check("auto_first_start", first_start, 100);
        check("auto_period", second_start - first_start, 100);
        check("auto_cnt", {16'd0, cnt_c}, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
